// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 control sequencer.
// Opcode values, T-state indices and the packed control word.
package sap1_pkg;

    localparam int OPCODE_W_DEF = 4;
    localparam int T_W          = 6;

    localparam logic [OPCODE_W_DEF-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W_DEF-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W_DEF-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W_DEF-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W_DEF-1:0] OP_HLT = 4'hF;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    localparam logic [T_W-1:0] T1_ONEHOT = 6'b000001;
    localparam logic [T_W-1:0] HALT_CODE = 6'b000000;

    typedef struct packed {
        logic pc_inc;
        logic pc_out;
        logic mar_load;
        logic ram_out;
        logic ir_load;
        logic ir_out;
        logic acc_load;
        logic acc_out;
        logic b_load;
        logic alu_sub;
        logic alu_out;
        logic out_load;
    } ctrl_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T1-T6 ring; an all-zero ring is HALT, left only through reset.
// Advances one state per edge while run=1; run=0 holds the current state.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           halt_entry,
    input  logic           early_wrap,
    output logic [T_W-1:0] t_state
);

    logic [T_W-1:0] t_state_q;
    logic [T_W-1:0] t_state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            t_state_q <= T1_ONEHOT;
        end else begin
            t_state_q <= t_state_d;
        end
    end

    always_comb begin
        t_state_d = t_state_q;
        if (t_state_q != HALT_CODE && run) begin
            if (halt_entry) begin
                t_state_d = HALT_CODE;
            end else if (early_wrap) begin
                t_state_d = T1_ONEHOT;
            end else begin
                t_state_d = {t_state_q[T_W-2:0], t_state_q[T_W-1]};
            end
        end
    end

    always_comb begin
        t_state = t_state_q;
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: fetch in T1-T3, opcode-decoded execute in T4-T6.
// Strobes are combinational from the ring state; run=0, reset and HALT force them low.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPCODE_W  = OPCODE_W_DEF,
    parameter bit EARLY_END = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                acc_load,
    output logic                acc_out,
    output logic                b_load,
    output logic                alu_sub,
    output logic                alu_out,
    output logic                out_load,
    output logic                halted,
    output logic [5:0]          t_state
);

    logic [T_W-1:0] ring;
    logic           is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic           halt_entry;
    logic           early_wrap;
    ctrl_t          ctrl;

    assign is_lda = (opcode == OPCODE_W'(OP_LDA));
    assign is_add = (opcode == OPCODE_W'(OP_ADD));
    assign is_sub = (opcode == OPCODE_W'(OP_SUB));
    assign is_out = (opcode == OPCODE_W'(OP_OUT));
    assign is_hlt = (opcode == OPCODE_W'(OP_HLT));
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

    assign halt_entry = ring[T4_IDX] && is_hlt;
    // ADD/SUB need T6 for the ALU writeback, so only LDA/OUT/NOP wrap early.
    assign early_wrap = EARLY_END &&
                        ((ring[T4_IDX] && (is_out || is_nop)) ||
                         (ring[T5_IDX] && is_lda));

    sap1_ring_counter u_ring (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_entry (halt_entry),
        .early_wrap (early_wrap),
        .t_state    (ring)
    );

    always_comb begin
        ctrl = '0;
        if (ring[T1_IDX]) begin
            ctrl.pc_out   = 1'b1;
            ctrl.mar_load = 1'b1;
        end
        if (ring[T2_IDX]) begin
            ctrl.pc_inc = 1'b1;
        end
        if (ring[T3_IDX]) begin
            ctrl.ram_out = 1'b1;
            ctrl.ir_load = 1'b1;
        end
        if (ring[T4_IDX]) begin
            if (is_lda || is_add || is_sub) begin
                ctrl.ir_out   = 1'b1;
                ctrl.mar_load = 1'b1;
            end else if (is_out) begin
                ctrl.acc_out  = 1'b1;
                ctrl.out_load = 1'b1;
            end
        end
        if (ring[T5_IDX]) begin
            if (is_lda) begin
                ctrl.ram_out  = 1'b1;
                ctrl.acc_load = 1'b1;
            end else if (is_add || is_sub) begin
                ctrl.ram_out = 1'b1;
                ctrl.b_load  = 1'b1;
            end
        end
        if (ring[T6_IDX] && (is_add || is_sub)) begin
            ctrl.alu_out  = 1'b1;
            ctrl.acc_load = 1'b1;
            ctrl.alu_sub  = is_sub;
        end
        // A stalled cycle must not repeat a PC increment or register load.
        if (reset || !run) begin
            ctrl = '0;
        end
    end

    assign pc_inc   = ctrl.pc_inc;
    assign pc_out   = ctrl.pc_out;
    assign mar_load = ctrl.mar_load;
    assign ram_out  = ctrl.ram_out;
    assign ir_load  = ctrl.ir_load;
    assign ir_out   = ctrl.ir_out;
    assign acc_load = ctrl.acc_load;
    assign acc_out  = ctrl.acc_out;
    assign b_load   = ctrl.b_load;
    assign alu_sub  = ctrl.alu_sub;
    assign alu_out  = ctrl.alu_out;
    assign out_load = ctrl.out_load;
    assign halted   = (ring == HALT_CODE) && !reset;
    assign t_state  = ring;

endmodule
